// File: rtl/param_counter.sv
`default_nettype none
// ============================================================================
//  Module   : param_counter
//  Brief    : Parametrised up/down event counter over [0, MAX] with enable,
//             synchronous clear, parallel load (clamped to MAX), clock
//             prescaler, one-cycle terminal-count pulse and sticky boundary
//             flag. Wrap or saturate at the boundary.
//  Macro    : PARAM_COUNTER_SAT_EN -- when defined, sat_mode selects
//             saturate (1) or wrap (0); when undefined the counter always
//             wraps and sat_mode is ignored.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module param_counter #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}},
    parameter int              DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // Prescaler needs at least one bit even when DIV is 1.
    localparam int              c_PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(DIV - 1);

    logic [WIDTH-1:0] r_count;
    logic [c_PW-1:0]  r_pre;
    logic             r_tc;
    logic             r_ovf;

    logic             w_step;
    logic             w_sat;
    logic [WIDTH-1:0] w_load_clamped;

`ifdef PARAM_COUNTER_SAT_EN
    assign w_sat = sat_mode;
`else
    // Saturate path compiled out; the AND keeps the port referenced.
    assign w_sat = sat_mode & 1'b0;
`endif

    // A step fires on the last enabled cycle of each prescaler period.
    assign w_step         = en && (r_pre == c_PRE_LAST);
    assign w_load_clamped = (load_val > MAX) ? MAX : load_val;

    // Prescaler, counter and flags: clr > load > step > hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (en) begin
                r_pre <= w_step ? '0 : r_pre + 1'b1;
            end
            if (w_step) begin
                if (dir) begin
                    if (r_count == MAX) begin
                        r_count <= w_sat ? MAX : '0;
                        r_tc    <= 1'b1;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end else begin
                    if (r_count == '0) begin
                        r_count <= w_sat ? '0 : MAX;
                        r_tc    <= 1'b1;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: doc/param_counter.md
# param_counter

Parametrised successor to the team's fixed 8-bit free-running counter. Counts up or down over a programmable range `[0, MAX]` with enable, synchronous clear, parallel load, clock prescaling, and a terminal-count pulse. Wrap and saturate behaviour are both supported. It is the common event/cycle counter for the NEAT hardware datapath (generation counters, evaluation timeouts, neuron index sweeps).

## Interface
- `WIDTH`, 8: counter width in bits (1..32).
- `MAX`, 2**WIDTH-1: terminal value; legal range 1..2**WIDTH-1.
- `DIV`, 1: prescaler ratio; one count step per `DIV` enabled cycles (1..65535).
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; gates both the prescaler and the counter.
- `clr`  in  1  synchronous clear.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  value written on `load`.
- `dir`  in  1  1 = count up, 0 = count down.
- `sat_mode`  in  1  1 = saturate at the boundary, 0 = wrap (see Configuration).
- `count`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal-count pulse, registered, one cycle wide.
- `ovf`  out  1  sticky boundary flag.

## Operation
- Per cycle, action priority is: `clr` > `load` > step > hold.
- `clr`: `count`←0, prescaler←0, `ovf`←0, `tc`←0.
- `load`: `count`←min(`load_val`, `MAX`), prescaler←0, `tc`←0; `ovf` is unchanged.
- Prescaler: internal counter of width clog2(`DIV`), minimum 1 bit.
  - Increments only when `en`=1.
  - Wraps `DIV-1`→0.
  - A step occurs when `en`=1 and prescaler=`DIV-1`.
  - With `DIV`=1, every enabled cycle steps.
  - `en`=0 freezes the prescaler.
- Step up (`dir`=1):
  - `count`<`MAX`: `count`+1.
  - `count`=`MAX`: boundary event. Wrap → 0; saturate → hold `MAX`.
- Step down (`dir`=0):
  - `count`>0: `count`-1.
  - `count`=0: boundary event. Wrap → `MAX`; saturate → hold 0.
- Boundary event: `tc`←1 for exactly that cycle and `ovf`←1.
- `ovf` stays set until `clr` or reset.
- In saturate mode, every further step attempt at the boundary is again a boundary event, so `tc` pulses on each.
- `dir` and `sat_mode` are sampled at the step; changing them mid-count is legal and takes effect on the next step.
- `count` never leaves `[0, MAX]`. Comparisons use WIDTH-bit unsigned arithmetic with no carry-out.

## Timing
- Reset (`rst`=0, asynchronous): `count`=0, `tc`=0, `ovf`=0, prescaler=0. These hold until the first rising edge with `rst`=1.
- Reset mid-count takes effect immediately, without waiting for a clock edge, and overrides every other input.
- Latency:
  - `count` reflects a step, load or clear on the rising edge where the condition was sampled.
  - `tc`/`ovf` are valid on the same edge as the boundary `count` update.
  - No combinational path from inputs to outputs.
- `clr` and `load` together: `clr` wins. `load` together with a step: `load` wins, and no boundary event is raised.
- `tc` is high for exactly one cycle per boundary event. It is never asserted by `load` or `clr`.

## Configuration
- Macro: `PARAM_COUNTER_SAT_EN`.
- Defined: saturate logic is compiled in, and `sat_mode` selects wrap or saturate as above.
- Undefined:
  - Saturate logic is removed and `sat_mode` is ignored.
  - The counter always wraps.
  - `tc`/`ovf` behave exactly as in wrap mode.

## Test plan
- Reset and wrap up (`WIDTH`=8, `MAX`=255, `DIV`=1):
  - Stimulus: hold `rst`=0 for 3 cycles, then `en`=1, `dir`=1.
  - Required: all outputs 0 during reset; `count` reaches 255 after 255 edges, then 0 on the next edge.
  - At that wrap edge `tc`=1 for one cycle and `ovf`=1 sticky.
- Modulo and down count (`MAX`=9):
  - Stimulus: `load_val`=200 with `load`=1, then `dir`=0 for 11 steps.
  - Required: `count`=9 after load (clamped); steps 9…0, then 9 with `tc` pulse.
- Saturation (macro defined, `sat_mode`=1, `MAX`=15, `dir`=1, from 14):
  - Required: count 14→15→15→15.
  - `tc` pulses on the 2nd and 3rd steps; `ovf`=1.
  - Repeat with the macro undefined: 14→15→0.
- Prescaler (`DIV`=4, `en`=1):
  - Required: `count` increments every 4th cycle.
  - Stimulus: drop `en` for 5 cycles mid-period.
  - Required: the period resumes where it stopped, with no lost or extra step.
- Priority:
  - Stimulus: `clr`=`load`=1 together. Required: `count`=0, `ovf`=0.
  - Stimulus: `load` at the boundary with a step pending. Required: `count`=`load_val`, `tc`=0.
- Async reset mid-count:
  - Stimulus: assert `rst`=0 between clock edges at `count`=37.
  - Required: `count`=0 before the next edge.
